// File: rtl/clause_bin_writer.sv
`default_nettype none
// ============================================================================
// Module   : clause_bin_writer
// Purpose  : Loads a full clause bin from a ready/valid clause stream, zero
//            fills the unused slots after an early last clause, and inserts
//            single learnt clauses into the lowest empty slot of the bin.
// Revision : 1.0 - initial release
// ============================================================================
module clause_bin_writer #(
  parameter int NUM_CLAUSES_A_BIN = 2,
  parameter int NUM_VARS_A_BIN    = 8,
  parameter int WIDTH_C_LEN       = 5,
  localparam int IDX_W = (NUM_CLAUSES_A_BIN > 1) ? $clog2(NUM_CLAUSES_A_BIN) : 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start_i,
  input  logic                                     c_valid_i,
  output logic                                     c_ready_o,
  input  logic                                     c_last_i,
  input  logic [NUM_VARS_A_BIN*3-1:0]              c_data_i,
  input  logic [WIDTH_C_LEN-1:0]                   c_len_i,
  input  logic                                     learnt_valid_i,
  input  logic [NUM_VARS_A_BIN*3-1:0]              learnt_data_i,
  input  logic [WIDTH_C_LEN-1:0]                   learnt_len_i,
  input  logic [WIDTH_C_LEN*NUM_CLAUSES_A_BIN-1:0] clause_len_i,
  output logic [NUM_CLAUSES_A_BIN-1:0]             wr_o,
  output logic [NUM_VARS_A_BIN*3-1:0]              var_value_o,
  output logic [WIDTH_C_LEN-1:0]                   clause_len_o,
  output logic                                     done_o,
  output logic                                     learnt_ack_o,
  output logic                                     learnt_full_o,
  output logic [IDX_W-1:0]                         learnt_idx_o
);

  localparam int DW = NUM_VARS_A_BIN * 3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CLEAR = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_SCAN  = 3'd4;
  localparam logic [2:0] S_INS   = 3'd5;

  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(NUM_CLAUSES_A_BIN - 1);

  logic [2:0]                   state;
  logic [2:0]                   state_nxt;
  logic [IDX_W-1:0]             cnt;
  logic [IDX_W-1:0]             cnt_nxt;
  logic                         accept;
  logic                         any_free;
  logic [IDX_W-1:0]             free_sel;
  logic                         scan_full;
  logic                         ack_q;
  logic [NUM_CLAUSES_A_BIN-1:0] wr_nxt;
  logic [DW-1:0]                var_nxt;
  logic [WIDTH_C_LEN-1:0]       len_nxt;
  logic                         done_nxt;
  logic                         ack_nxt;
  logic [IDX_W-1:0]             idx_nxt;

  // Slot k drives strobe bit NUM_CLAUSES_A_BIN-1-k, so slot 0 sits in the MSB.
  function automatic logic [NUM_CLAUSES_A_BIN-1:0] slot_strobe(input logic [IDX_W-1:0] k);
    logic [NUM_CLAUSES_A_BIN-1:0] v;
    v = '0;
    for (int j = 0; j < NUM_CLAUSES_A_BIN; j++) begin
      if (int'(k) == j) v[NUM_CLAUSES_A_BIN-1-j] = 1'b1;
    end
    return v;
  endfunction

  assign c_ready_o = (state == S_LOAD);
  assign accept    = c_valid_i & c_ready_o;

  // A full bin is answered straight from the scan cycle; an insert answers one cycle later.
  assign scan_full     = (state == S_SCAN) & ~any_free;
  assign learnt_ack_o  = ack_q | scan_full;
  assign learnt_full_o = scan_full;

  // Lowest-numbered slot whose reported length is zero (downward loop, last hit wins).
  always_comb begin
    any_free = 1'b0;
    free_sel = '0;
    for (int k = NUM_CLAUSES_A_BIN - 1; k >= 0; k--) begin
      if (clause_len_i[(NUM_CLAUSES_A_BIN-k)*WIDTH_C_LEN-1 -: WIDTH_C_LEN] == '0) begin
        any_free = 1'b1;
        free_sel = IDX_W'(k);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state decision; a load request beats a learnt request in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start_i)             state_nxt = S_LOAD;
        else if (learnt_valid_i) state_nxt = S_SCAN;
      end
      S_LOAD: begin
        if (accept) begin
          if (cnt == LAST_SLOT) state_nxt = S_DONE;
          else if (c_last_i)    state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: if (cnt == LAST_SLOT) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      S_SCAN:  state_nxt = any_free ? S_INS : S_IDLE;
      S_INS:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Values the registered outputs take on the next edge; everything idles at zero.
  always_comb begin
    cnt_nxt  = cnt;
    wr_nxt   = '0;
    var_nxt  = '0;
    len_nxt  = '0;
    done_nxt = 1'b0;
    ack_nxt  = 1'b0;
    idx_nxt  = '0;
    case (state)
      S_IDLE: if (start_i) cnt_nxt = '0;
      S_LOAD: begin
        if (accept) begin
          wr_nxt  = slot_strobe(cnt);
          var_nxt = c_data_i;
          len_nxt = c_len_i;
          cnt_nxt = cnt + IDX_W'(1);
        end
      end
      S_CLEAR: begin
        wr_nxt  = slot_strobe(cnt);
        cnt_nxt = cnt + IDX_W'(1);
      end
      S_DONE: begin
        done_nxt = 1'b1;
        cnt_nxt  = '0;
      end
      S_SCAN: begin
        if (any_free) begin
          wr_nxt  = slot_strobe(free_sel);
          var_nxt = learnt_data_i;
          len_nxt = learnt_len_i;
          ack_nxt = 1'b1;
          idx_nxt = free_sel;
        end
      end
      default: ;
    endcase
  end

  // Slot counter and registered bin-write / handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt          <= '0;
      wr_o         <= '0;
      var_value_o  <= '0;
      clause_len_o <= '0;
      done_o       <= 1'b0;
      ack_q        <= 1'b0;
      learnt_idx_o <= '0;
    end else begin
      cnt          <= cnt_nxt;
      wr_o         <= wr_nxt;
      var_value_o  <= var_nxt;
      clause_len_o <= len_nxt;
      done_o       <= done_nxt;
      ack_q        <= ack_nxt;
      learnt_idx_o <= idx_nxt;
    end
  end

endmodule
`default_nettype wire
